// File: rtl/adpll_hop_seq.sv
// -----------------------------------------------------------------------------
// adpll_hop_seq
//
// Channel-hop sequencer for adpll_ctr. This block is a bus master on the
// ADPLL CPU register interface. On a hop request it does the following:
//   1. disables the loop,
//   2. programs MODE, then FCW,
//   3. re-enables the loop,
//   4. waits until channel_lock has been high for LOCK_HOLD consecutive cycles.
// It then reports done (or err, once lock-timeout retries are used up) to the
// radio MAC.
//
// Register map (fixed): EN @0 (bit0), MODE @1 (bits 1:0), FCW @2 (bits 25:0).
//
// Ports
//   clk, rst           32 MHz reference clock; asynchronous active-high reset
//   req                hop request (sampled only while idle)
//   req_mode[1:0]      PD=0, TEST=1, RX=2, TX=3
//   req_fcw[25:0]      channel word, MHz*16384
//   busy               hop in progress
//   done / err         one-cycle completion / failure pulses
//   locked             last hop succeeded and lock is still held
//   retries[1:0]       timeout retries consumed by the current/last hop
//   lock_in            channel_lock from adpll_ctr
//   sel, write         bus strobes
//   address[ADDR_W-1:0], data_out[31:0]  bus address / write data
//   ready              bus write completion
//
// Configuration macro: ADPLL_HOP_SEQ_TIMEOUT_EN
//   defined   : WAIT_LOCK times out after LOCK_TIMEOUT cycles. A timeout
//               re-runs the write sequence up to MAX_RETRY times, then
//               pulses err.
//   undefined : WAIT_LOCK waits indefinitely. err and retries are tied to 0.
// -----------------------------------------------------------------------------
module adpll_hop_seq #(
  parameter int ADDR_W       = 5,
  parameter int LOCK_HOLD    = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        req_mode,
  input  logic [25:0]       req_fcw,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              locked,
  output logic [1:0]        retries,
  input  logic              lock_in,
  output logic              sel,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_out,
  input  logic              ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DIS,
    S_WR_MODE,
    S_WR_FCW,
    S_WR_EN,
    S_WAIT_LOCK
  } state_e;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } mode_e;

  localparam logic [ADDR_W-1:0] ADDR_EN   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_MODE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_FCW  = ADDR_W'(2);

  localparam int                HOLD_W    = $clog2(LOCK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [25:0]         fcw_q, fcw_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                locked_q, locked_d;
  logic                sel_q, sel_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [31:0]         data_q, data_d;
  logic                lock_ok;

`ifdef ADPLL_HOP_SEQ_TIMEOUT_EN
  localparam int              TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      retries_q, retries_d;
  logic            err_q, err_d;
`endif

  // Success: this cycle's lock sample completes LOCK_HOLD consecutive highs.
  assign lock_ok = lock_in && (hold_q == HOLD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    fcw_d    = fcw_q;
    hold_d   = '0;
    done_d   = 1'b0;
    // Lock is lost as soon as channel_lock drops, whatever the state.
    locked_d = locked_q & lock_in;
`ifdef ADPLL_HOP_SEQ_TIMEOUT_EN
    to_d      = '0;
    retries_d = retries_q;
    err_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_WR_DIS;
          mode_d   = req_mode;
          fcw_d    = req_fcw;
          locked_d = 1'b0;
`ifdef ADPLL_HOP_SEQ_TIMEOUT_EN
          retries_d = '0;
`endif
        end
      end

      S_WR_DIS: begin
        if (ready) state_d = S_WR_MODE;
      end

      S_WR_MODE: begin
        if (ready) begin
          // Power-down needs no channel word and has no lock to wait for.
          if (mode_q == MODE_PD) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WR_FCW;
          end
        end
      end

      S_WR_FCW: begin
        if (ready) state_d = S_WR_EN;
      end

      S_WR_EN: begin
        if (ready) state_d = S_WAIT_LOCK;
      end

      S_WAIT_LOCK: begin
        hold_d = lock_in ? hold_q + 1'b1 : '0;
`ifdef ADPLL_HOP_SEQ_TIMEOUT_EN
        to_d   = to_q + 1'b1;
`endif
        // Success is tested first so it wins a same-cycle timeout.
        if (lock_ok) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          locked_d = 1'b1;
          hold_d   = '0;
`ifdef ADPLL_HOP_SEQ_TIMEOUT_EN
          to_d     = '0;
        end else if (to_q == TO_LAST) begin
          hold_d = '0;
          to_d   = '0;
          if (retries_q < 2'(MAX_RETRY)) begin
            retries_d = retries_q + 1'b1;
            state_d   = S_WR_DIS;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = S_IDLE;
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being
    // entered. They hold while ready is low because the state holds.
    sel_d     = 1'b0;
    write_d   = 1'b0;
    address_d = '0;
    data_d    = '0;
    unique case (state_d)
      S_WR_DIS: begin
        sel_d     = 1'b1;
        write_d   = 1'b1;
        address_d = ADDR_EN;
      end
      S_WR_MODE: begin
        sel_d     = 1'b1;
        write_d   = 1'b1;
        address_d = ADDR_MODE;
        data_d    = {30'd0, mode_d};
      end
      S_WR_FCW: begin
        sel_d     = 1'b1;
        write_d   = 1'b1;
        address_d = ADDR_FCW;
        data_d    = {6'd0, fcw_d};
      end
      S_WR_EN: begin
        sel_d     = 1'b1;
        write_d   = 1'b1;
        address_d = ADDR_EN;
        data_d    = 32'd1;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers. The asynchronous reset drops sel immediately, so a
  // write in flight is abandoned rather than completed.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      fcw_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      locked_q  <= 1'b0;
      sel_q     <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      fcw_q     <= fcw_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      locked_q  <= locked_d;
      sel_q     <= sel_d;
      write_q   <= write_d;
      address_q <= address_d;
      data_q    <= data_d;
    end
  end

`ifdef ADPLL_HOP_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q      <= '0;
      retries_q <= '0;
      err_q     <= 1'b0;
    end else begin
      to_q      <= to_d;
      retries_q <= retries_d;
      err_q     <= err_d;
    end
  end

  assign err     = err_q;
  assign retries = retries_q;
`else
  assign err     = 1'b0;
  assign retries = 2'd0;

  // Timeout parameters have no effect in this build; fold them into a sink.
  logic unused_cfg;
  assign unused_cfg = ^{32'(LOCK_TIMEOUT), 32'(MAX_RETRY)};
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign locked   = locked_q;
  assign sel      = sel_q;
  assign write    = write_q;
  assign address  = address_q;
  assign data_out = data_q;

endmodule

// File: doc/adpll_hop_seq.md
# adpll_hop_seq

Channel-hop sequencer for `adpll_ctr`. It acts as a bus master on the ADPLL CPU register interface (`sel`/`write`/`address`/`data_in`/`ready`). On a hop request it disables the loop, programs the mode and FCW, re-enables the loop, and then waits for `channel_lock` to hold stable. It retries on lock timeout and reports done or error to the radio MAC.

## Interface
Parameters:
- `ADDR_W`, 5: ADPLL register address width.
- `LOCK_HOLD`, 4: consecutive lock-high cycles needed to declare lock (≥1).
- `LOCK_TIMEOUT`, 4096: max cycles in WAIT_LOCK per attempt; 128 µs at 32 MHz.
- `MAX_RETRY`, 3: re-sequence attempts after the first timeout.

Ports:
- `clk` in 1: 32 MHz reference clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: hop request, sampled only in IDLE.
- `req_mode` in 2: PD=0, TEST=1, RX=2, TX=3.
- `req_fcw` in 26: channel word, MHz×16384.
- `busy` out 1: high from the cycle after an accepted `req` until return to IDLE.
- `done` out 1: 1-cycle pulse on success.
- `err` out 1: 1-cycle pulse when retries are exhausted.
- `locked` out 1: successful hop completed and lock still held.
- `retries` out 2: attempts consumed in the current/last hop.
- `lock_in` in 1: `channel_lock` from `adpll_ctr`.
- `sel`, `write` out 1: bus strobes.
- `address` out ADDR_W.
- `data_out` out 32: drives `adpll_ctr.data_in`.
- `ready` in 1: bus completion.

## Operation
- Register map, fixed: EN at address 0 (data bit0); MODE at address 1 (bits 1:0); FCW at address 2 (bits 25:0). Unused data bits are 0.
- `req_mode` and `req_fcw` are latched on the accepting cycle. `req` while busy is ignored, with no queueing.
- States, in order: IDLE → WR_DIS (EN=0) → WR_MODE → WR_FCW → WR_EN (EN=1) → WAIT_LOCK → IDLE.
- PD mode: WR_FCW, WR_EN and WAIT_LOCK are skipped. `done` pulses after WR_MODE completes, and `locked` stays 0.
- Bus rule:
  - `sel`=`write`=1 in every WR_* state.
  - `address`/`data_out` are constant until `ready` is sampled high.
  - The state advances on that edge.
  - `sel` stays high across back-to-back writes and drops on exit to WAIT_LOCK or IDLE.
  - When `sel`=0, `address` and `data_out` are 0.
- WAIT_LOCK uses two counters:
  - Hold counter: increments while `lock_in`=1 and clears on `lock_in`=0. Reaching LOCK_HOLD gives success, which pulses `done`, sets `locked` and returns to IDLE.
  - Timeout counter: counts every cycle. Reaching LOCK_TIMEOUT without success is a timeout.
- If success and timeout occur on the same cycle, success wins.
- Timeout handling:
  - If `retries` < MAX_RETRY: increment `retries` and go to WR_DIS; both counters clear.
  - Otherwise: pulse `err`, go to IDLE, and leave `locked`=0.
- `retries` clears on an accepted `req`. It saturates and does not wrap.
- `locked` clears on `lock_in`=0 (sampled in any state) and on an accepted `req`.

## Timing
- All outputs are registered.
- Reset state: IDLE, with `busy`, `done`, `err`, `locked`, `sel`, `write` = 0, `address`=0, `data_out`=0, `retries`=0 and both counters 0.
- Reset asserted mid-transaction drops `sel` asynchronously. No partial write is completed.
- Latency with `ready` tied high and `req` accepted at cycle 0:
  - `sel` high cycles 1–4, with addresses 0, 1, 2, 0.
  - WAIT_LOCK starts at cycle 5.
- With `lock_in` high from cycle 5 and LOCK_HOLD=4, `done` and `locked` rise at cycle 9 and `busy` falls at cycle 9.
- Each cycle of `ready`=0 stretches the current write by one cycle.

## Configuration
- `ADPLL_HOP_SEQ_TIMEOUT_EN`, defined: timeout counter, retry path and `err` are present as described.
- Undefined:
  - WAIT_LOCK waits indefinitely for LOCK_HOLD cycles of lock.
  - The timeout counter is not synthesized.
  - `err` and `retries` are tied to 0.

## Test plan
- Reset, then `req` with mode=RX and fcw=2480.0×16384=40632320, `ready`=1, `lock_in` high from cycle 5 → writes (0,0), (1,2), (2,40632320), (0,1) on cycles 1–4, `done` at cycle 9, `locked`=1.
- `ready` low for 3 cycles during the FCW write → address 2 and its data are held for 4 cycles, and every later event slips by 3.
- `lock_in` toggles 1,1,0,1,1,1,1 → the hold counter restarts at the 0, and `done` comes 4 cycles after the last rise.
- `lock_in`=0, LOCK_TIMEOUT=16, MAX_RETRY=3 → 4 full write sequences, `err` pulse, `retries`=3, `locked`=0. Without the macro, `busy` stays high.
- mode=PD → only 2 writes, `done` at cycle 3, `locked`=0. A `req` issued while busy is ignored. `rst` during WR_FCW forces `sel`=0 immediately and `busy`=0.
